// File: rtl/controle_jogo_param.sv
// Game controller for a memory ("genius"-style) sequence game.
// Plays the note sequence for the current round, collects the player's
// moves, counts errors (lives) and reports win/loss.
// Optional move timeout: define TIMEOUT_JOGADA_EN to limit each move to
// T_JOGADA cycles; without it the controller waits indefinitely for a move.
module controle_jogo_param #(
  parameter int N_RODADAS = 16,
  parameter int MAX_ERROS = 3,
  parameter int T_NOTA    = 50000000,
  parameter int T_JOGADA  = 250000000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         jogar,
  input  logic                         treinamento,
  input  logic                         tem_jogada,
  input  logic                         tem_botao_pressionado,
  input  logic                         botoesIgualMemoria,
  output logic [$clog2(N_RODADAS)-1:0] endereco,
  output logic [$clog2(N_RODADAS)-1:0] rodada,
  output logic [3:0]                   erros,
  output logic                         mostraJ,
  output logic                         mostraB,
  output logic                         enable_registrador_botoes,
  output logic                         serrou,
  output logic                         rodada_ok,
  output logic                         timeout,
  output logic                         pronto,
  output logic                         acertou,
  output logic                         perdeu,
  output logic [4:0]                   db_estado
);

  localparam int AW    = $clog2(N_RODADAS);
  localparam int T_MAX = (T_NOTA > T_JOGADA) ? T_NOTA : T_JOGADA;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [AW-1:0] ULTIMA   = AW'(N_RODADAS - 1);
  localparam logic [4:0]    ERROS_FIM = 5'(MAX_ERROS);

  typedef enum logic [4:0] {
    INICIAL       = 5'h00,
    PREPARA       = 5'h01,
    PROX_RODADA   = 5'h02,
    ESPERA_JOGADA = 5'h03,
    REGISTRA      = 5'h04,
    COMPARA       = 5'h05,
    PROXIMO       = 5'h06,
    TOCA_NOTA     = 5'h07,
    FIM_ACERTOU   = 5'h0A,
    FIM_RODADA    = 5'h0B,
    FIM_PERDEU    = 5'h0D,
    ERROU         = 5'h0E,
    ESPERA_SOLTAR = 5'h12,
    TREINO        = 5'h16
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [AW-1:0]   endereco_q, endereco_d;
  logic [AW-1:0]   rodada_q, rodada_d;
  logic [3:0]      erros_q, erros_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            limpa_timer;
  logic            conta_timer;
  logic            nota_fim;
  logic [4:0]      erros_mais_um;

  assign nota_fim      = (timer_q == TW'(T_NOTA - 1));
  assign erros_mais_um = {1'b0, erros_q} + 5'd1;

`ifdef TIMEOUT_JOGADA_EN
  logic jogada_fim;
  assign jogada_fim = (timer_q == TW'(T_JOGADA - 1));
`endif

  // State and counter registers; reset forces the idle state asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= '0;
      rodada_q   <= '0;
      erros_q    <= '0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      erros_q    <= erros_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state and counter updates; the timer restarts on every state change.
  always_comb begin
    estado_d    = estado_q;
    endereco_d  = endereco_q;
    rodada_d    = rodada_q;
    erros_d     = erros_q;
    limpa_timer = 1'b0;
    conta_timer = 1'b0;
    timer_d     = timer_q;
    case (estado_q)
      INICIAL: if (jogar) estado_d = PREPARA;
      PREPARA: begin
        endereco_d  = '0;
        rodada_d    = '0;
        erros_d     = '0;
        limpa_timer = 1'b1;
        estado_d    = treinamento ? TREINO : TOCA_NOTA;
      end
      TOCA_NOTA: begin
        conta_timer = 1'b1;
        if (nota_fim) begin
          limpa_timer = 1'b1;
          if (endereco_q == rodada_q) begin
            endereco_d = '0;
            estado_d   = ESPERA_JOGADA;
          end else begin
            endereco_d = endereco_q + 1'b1;
          end
        end
      end
      ESPERA_JOGADA: begin
        if (tem_jogada) estado_d = REGISTRA;
`ifdef TIMEOUT_JOGADA_EN
        else if (jogada_fim) estado_d = ERROU;
        conta_timer = 1'b1;
`endif
      end
      REGISTRA: estado_d = ESPERA_SOLTAR;
      ESPERA_SOLTAR: if (!tem_botao_pressionado) estado_d = COMPARA;
      COMPARA: begin
        if (!botoesIgualMemoria)         estado_d = ERROU;
        else if (endereco_q == rodada_q) estado_d = FIM_RODADA;
        else                             estado_d = PROXIMO;
      end
      PROXIMO: begin
        if (endereco_q != rodada_q) endereco_d = endereco_q + 1'b1;
        limpa_timer = 1'b1;
        estado_d    = ESPERA_JOGADA;
      end
      ERROU: begin
        if (erros_q != 4'd15) erros_d = erros_q + 1'b1;
        if (erros_mais_um == ERROS_FIM) begin
          estado_d = FIM_PERDEU;
        end else begin
          endereco_d  = '0;
          limpa_timer = 1'b1;
          estado_d    = TOCA_NOTA;
        end
      end
      FIM_RODADA: begin
        conta_timer = 1'b1;
        if (nota_fim) estado_d = (rodada_q == ULTIMA) ? FIM_ACERTOU : PROX_RODADA;
      end
      PROX_RODADA: begin
        if (rodada_q != ULTIMA) rodada_d = rodada_q + 1'b1;
        endereco_d  = '0;
        limpa_timer = 1'b1;
        estado_d    = TOCA_NOTA;
      end
      FIM_ACERTOU, FIM_PERDEU: if (jogar) estado_d = PREPARA;
      TREINO: if (!treinamento) estado_d = INICIAL;
      default: estado_d = INICIAL;
    endcase
    if (limpa_timer || (estado_d != estado_q)) timer_d = '0;
    else if (conta_timer)                      timer_d = timer_q + 1'b1;
  end

  // Moore output decode from the registered state and counters.
  always_comb begin
    mostraJ                   = 1'b0;
    mostraB                   = 1'b0;
    enable_registrador_botoes = 1'b0;
    serrou                    = 1'b0;
    rodada_ok                 = 1'b0;
    timeout                   = 1'b0;
    pronto                    = 1'b0;
    acertou                   = 1'b0;
    perdeu                    = 1'b0;
    case (estado_q)
      TOCA_NOTA: mostraJ = 1'b1;
      ESPERA_JOGADA: begin
        mostraB = 1'b1;
`ifdef TIMEOUT_JOGADA_EN
        timeout = jogada_fim;
`endif
      end
      REGISTRA: enable_registrador_botoes = 1'b1;
      ERROU: serrou = 1'b1;
      FIM_RODADA: begin
        mostraB   = 1'b1;
        rodada_ok = (timer_q == '0);
      end
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_PERDEU: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      TREINO: mostraB = 1'b1;
      default: ;
    endcase
  end

  assign endereco  = endereco_q;
  assign rodada    = rodada_q;
  assign erros     = erros_q;
  assign db_estado = estado_q;

endmodule
